// File: rtl/sata_arb_pkg.sv
// Shared types and helpers for the SATA host-bus arbiter.
package sata_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_DONE   = 3'd3,
        ST_OWNED  = 3'd4
    } arb_state_e;

    // Shadow-register address of the ATA command register
    localparam logic [4:0] CMD_ADDR_DEF = 5'h07;

    // Width of a channel index; never narrower than one bit
    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sata_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i.
module sata_rr_pick
    import sata_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     idx_o,
    output logic              any_o
);

    // Scan channels in rotated order and keep the first one requesting
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % NUM_CH]) begin
                any_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % NUM_CH);
                gnt_o[(int'(ptr_i) + i) % NUM_CH] = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/sata_host_arbiter.sv
// N-channel round-robin arbiter onto the SATA core shadow-register host bus.
// Optional build macro SATA_ARB_IPF_ROUTE_EN routes IPF to the channel that
// last wrote the command register and holds that channel's grant while IPF
// is pending; without it IPF is broadcast to every channel.
module sata_host_arbiter
    import sata_arb_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                RD_LAT   = 1,
    parameter int                HOLD_TMO = 1023,
    parameter logic [ADDR_W-1:0] CMD_ADDR = ADDR_W'(CMD_ADDR_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH-1:0]        ch_lock,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_ipf,
    output logic                     host_read_en,
    output logic                     host_write_en,
    output logic [ADDR_W-1:0]        host_addr,
    output logic [DATA_W-1:0]        host_wdata,
    input  logic [DATA_W-1:0]        host_rdata,
    input  logic                     write_hold,
    input  logic                     read_hold,
    input  logic                     ipf
);

    localparam int IW = idx_w(NUM_CH);
    // Counter serves both the hold timeout and the read-latency wait
    localparam int CW = ($clog2(HOLD_TMO + 1) > 3) ? $clog2(HOLD_TMO + 1) : 3;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [NUM_CH-1:0]   ipf_q;

    logic [NUM_CH-1:0]   pick_oh_s;
    logic [IW-1:0]       pick_idx_s;
    logic                pick_any_s;
    logic [IW-1:0]       lat_idx_s;
    logic [IW-1:0]       next_ptr_s;
    logic                hold_s;
    logic                lock_eff_s;
    logic [NUM_CH-1:0]   ipf_vec_s;
    logic                wr_en_s;
    logic                rd_en_s;

    sata_rr_pick #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_pick (
        .req_i (ch_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    // A new access comes from the rr winner in IDLE, or the owner while OWNED
    assign lat_idx_s  = (state_q == ST_OWNED) ? owner_q : pick_idx_s;
    assign next_ptr_s = (owner_q == IW'(NUM_CH - 1)) ? '0 : owner_q + IW'(1);
    assign hold_s     = we_q ? write_hold : read_hold;

`ifdef SATA_ARB_IPF_ROUTE_EN
    logic [NUM_CH-1:0] tgt_q;

    // Remember the channel that last wrote the command register
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q <= '0;
        end else if (wr_en_s && (addr_q == CMD_ADDR)) begin
            tgt_q <= gnt_q;
        end else begin
            tgt_q <= tgt_q;
        end
    end

    assign lock_eff_s = ch_lock[owner_q] | (ipf & tgt_q[owner_q]);
    assign ipf_vec_s  = ipf ? tgt_q : '0;
`else
    assign lock_eff_s = ch_lock[owner_q];
    assign ipf_vec_s  = {NUM_CH{ipf}};
`endif

    // Next-state and bus-enable logic; enables gate directly on the live hold
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        err_d   = '0;
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    owner_d = pick_idx_s;
                    gnt_d   = pick_oh_s;
                    we_d    = ch_we[lat_idx_s];
                    addr_d  = ch_addr[int'(lat_idx_s)*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[int'(lat_idx_s)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hold_s) begin
                    if (cnt_q == CW'(HOLD_TMO - 1)) begin
                        err_d   = gnt_q;
                        gnt_d   = '0;
                        ptr_d   = next_ptr_s;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (we_q) begin
                    wr_en_s = 1'b1;
                    ack_d   = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    rd_en_s = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    rdata_d = host_rdata;
                    ack_d   = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                ptr_d = next_ptr_s;
                if (lock_eff_s) begin
                    state_d = ST_OWNED;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (ch_req[owner_q]) begin
                    we_d    = ch_we[lat_idx_s];
                    addr_d  = ch_addr[int'(lat_idx_s)*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[int'(lat_idx_s)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else if (!lock_eff_s) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OWNED;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            ipf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ipf_q   <= ipf_vec_s;
        end
    end

    assign ch_ack        = ack_q;
    assign ch_err        = err_q;
    assign ch_rdata      = rdata_q;
    assign ch_gnt        = gnt_q;
    assign ch_ipf        = ipf_q;
    assign host_write_en = wr_en_s;
    assign host_read_en  = rd_en_s;
    assign host_addr     = addr_q;
    assign host_wdata    = wdata_q;

endmodule

// File: tb/tb_sata_host_arbiter.sv
// Directed self-checking bench for sata_host_arbiter (RD_LAT=2, HOLD_TMO=16).
module tb_sata_host_arbiter;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int RD_LAT   = 2;
    localparam int HOLD_TMO = 16;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH-1:0]        ch_lock;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_err;
    logic [DATA_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_ipf;
    logic                     host_read_en;
    logic                     host_write_en;
    logic [ADDR_W-1:0]        host_addr;
    logic [DATA_W-1:0]        host_wdata;
    logic [DATA_W-1:0]        host_rdata;
    logic                     write_hold;
    logic                     read_hold;
    logic                     ipf;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] dev_rdata;
    logic [1:0]        rd_pipe;

    sata_host_arbiter #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .HOLD_TMO (HOLD_TMO),
        .CMD_ADDR (5'h07)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_req        (ch_req),
        .ch_we         (ch_we),
        .ch_lock       (ch_lock),
        .ch_addr       (ch_addr),
        .ch_wdata      (ch_wdata),
        .ch_ack        (ch_ack),
        .ch_err        (ch_err),
        .ch_rdata      (ch_rdata),
        .ch_gnt        (ch_gnt),
        .ch_ipf        (ch_ipf),
        .host_read_en  (host_read_en),
        .host_write_en (host_write_en),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .write_hold    (write_hold),
        .read_hold     (read_hold),
        .ipf           (ipf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device model: read data is valid only RD_LAT cycles after the enable
    always @(posedge clk) rd_pipe <= {rd_pipe[0], host_read_en};
    assign host_rdata = rd_pipe[1] ? dev_rdata : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic we, input logic [4:0] a, input logic [31:0] d);
        ch_we[c]                = we;
        ch_addr[c*ADDR_W +: ADDR_W] = a;
        ch_wdata[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ch_req     = '0;
        ch_lock    = '0;
        write_hold = 1'b0;
        read_hold  = 1'b0;
        ipf        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, got, extra, n, both, nw, acks, intr, errat, wc;
        logic [NUM_CH-1:0] order [8];
        logic [NUM_CH-1:0] nxt, errv, gv;
        reset = 1'b1; ch_req = '0; ch_we = '0; ch_lock = '0; ch_addr = '0; ch_wdata = '0;
        write_hold = 1'b0; read_hold = 1'b0; ipf = 1'b0; dev_rdata = 32'h50;
        repeat (3) tick();
        // Reset state
        check("rst_gnt", ch_gnt, 0);
        check("rst_ack", ch_ack, 0);
        check("rst_err", ch_err, 0);
        check("rst_rdata", ch_rdata, 0);
        check("rst_wen", host_write_en, 0);
        check("rst_ren", host_read_en, 0);
        check("rst_addr", host_addr, 0);
        check("rst_wdata", host_wdata, 0);
        check("rst_ipf", ch_ipf, 0);
        reset = 1'b0;

        // Single write on channel 1
        set_ch(1, 1'b1, 5'h07, 32'hEC00_0000);
        ch_req = 4'b0010;
        tick();
        check("wr_gnt", ch_gnt, 4'b0010);
        check("wr_en", host_write_en, 1);
        check("wr_addr", host_addr, 5'h07);
        check("wr_data", host_wdata, 32'hEC00_0000);
        check("wr_no_ren", host_read_en, 0);
        check("wr_ack_early", ch_ack, 0);
        tick();
        check("wr_ack", ch_ack, 4'b0010);
        check("wr_en_width", host_write_en, 0);
        ch_req = '0;
        tick();
        check("wr_release", ch_gnt, 0);
        check("wr_ack_pulse", ch_ack, 0);

        // Read on channel 0 with RD_LAT=2
        set_ch(0, 1'b0, 5'h07, 32'h0);
        ch_req = 4'b0001;
        tick();
        check("rd_en", host_read_en, 1);
        check("rd_gnt", ch_gnt, 4'b0001);
        check("rd_addr", host_addr, 5'h07);
        lat = 0; got = 0; extra = 0;
        for (int i = 1; i <= 8 && got == 0; i++) begin
            tick();
            if (host_read_en) extra++;
            if (ch_ack[0]) begin
                got = 1;
                lat = i;
            end
        end
        check("rd_lat", lat, 3);
        check("rd_data", ch_rdata, 32'h50);
        check("rd_en_width", extra, 0);
        ch_req = '0;
        tick();
        check("rd_data_hold", ch_rdata, 32'h50);

        // Reset in the middle of a stalled access
        set_ch(1, 1'b1, 5'h03, 32'hAAAA);
        write_hold = 1'b1;
        ch_req = 4'b0010;
        tick();
        tick();
        check("mid_stall", host_write_en, 0);
        reset = 1'b1;
        tick();
        check("mid_gnt", ch_gnt, 0);
        ch_req = '0; write_hold = 1'b0; reset = 1'b0;
        tick();
        tick();
        check("mid_ack", ch_ack, 0);
        check("mid_err", ch_err, 0);
        check("mid_wen", host_write_en, 0);

        // Fairness: all channels request continuously; read_hold must not stall writes
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 5'(c), 32'h1111 * (c + 1));
        read_hold = 1'b1;
        ch_req = 4'hF;
        n = 0; both = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            tick();
            if (host_write_en && host_read_en) both++;
            if (host_write_en) begin
                order[n] = ch_gnt;
                n++;
            end
        end
        ch_req = '0; read_hold = 1'b0;
        check("fair_cnt", n, 8);
        check("fair_excl", both, 0);
        for (int k = 0; k < 8; k++) check($sformatf("fair_gnt%0d", k), order[k], 4'b0001 << (k % 4));

        // Lock: channel 2 does three locked writes while 0 and 1 wait
        do_reset();
        set_ch(2, 1'b1, 5'h02, 32'h100);
        ch_lock = 4'b0100;
        ch_req = 4'b0100;
        tick();
        check("lk_first", host_write_en, 1);
        check("lk_first_gnt", ch_gnt, 4'b0100);
        set_ch(0, 1'b1, 5'h00, 32'h0);
        set_ch(1, 1'b1, 5'h01, 32'h1);
        ch_req = 4'b0111;
        nw = 1; acks = 0; intr = 0; nxt = '0;
        for (int i = 0; i < 60 && nxt == '0; i++) begin
            tick();
            if (acks < 3 && (ch_gnt & 4'b1011) != 4'b0000) intr++;
            if (host_write_en) begin
                if (ch_gnt == 4'b0100) begin
                    check("lk_wdata", host_wdata, 32'h100 + nw);
                    nw++;
                end else begin
                    nxt = ch_gnt;
                end
            end
            if (ch_ack[2]) begin
                acks++;
                if (acks < 3) begin
                    set_ch(2, 1'b1, 5'h02, 32'h100 + acks);
                end else begin
                    ch_req[2]  = 1'b0;
                    ch_lock[2] = 1'b0;
                end
            end
        end
        check("lk_writes", nw, 3);
        check("lk_intrude", intr, 0);
        check("lk_next", nxt, 4'b0001);

        // Hold for 10 cycles, then issue as soon as hold falls
        do_reset();
        set_ch(1, 1'b1, 5'h03, 32'h1234);
        write_hold = 1'b1;
        ch_req = 4'b0010;
        wc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (host_write_en) wc++;
        end
        check("hold_stall", wc, 0);
        check("hold_gnt", ch_gnt, 4'b0010);
        write_hold = 1'b0;
        #1;
        check("hold_issue", host_write_en, 1);
        check("hold_wdata", host_wdata, 32'h1234);
        tick();
        check("hold_ack", ch_ack, 4'b0010);
        check("hold_noerr", ch_err, 0);
        ch_req = '0;
        tick();

        // Timeout: hold never falls
        do_reset();
        set_ch(2, 1'b1, 5'h04, 32'h55);
        write_hold = 1'b1;
        ch_req = 4'b0100;
        tick();
        errat = 0; wc = 0; errv = '0; gv = '1;
        for (int i = 1; i <= 40 && errat == 0; i++) begin
            tick();
            if (host_write_en) wc++;
            if (ch_err != '0) begin
                errat = i;
                errv  = ch_err;
                gv    = ch_gnt;
            end
        end
        check("tmo_at", errat, HOLD_TMO);
        check("tmo_err", errv, 4'b0100);
        check("tmo_nowen", wc, 0);
        check("tmo_gnt", gv, 0);
        ch_req = '0; write_hold = 1'b0;
        tick();
        check("tmo_pulse", ch_err, 0);
        check("tmo_noack", ch_ack, 0);
        check("tmo_idle", host_write_en, 0);

        // IPF routing after channel 3 writes the command register
        do_reset();
        set_ch(3, 1'b1, 5'h07, 32'hEC);
        ch_req = 4'b1000;
        tick();
        check("ipf_wr", host_write_en, 1);
        tick();
        ch_req = '0;
        tick();
        check("ipf_low", ch_ipf, 0);
        ipf = 1'b1;
        tick();
`ifdef SATA_ARB_IPF_ROUTE_EN
        check("ipf_route", ch_ipf, 4'b1000);
`else
        check("ipf_route", ch_ipf, 4'b1111);
`endif
        ipf = 1'b0;
        tick();
        check("ipf_clear", ch_ipf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
